// File: rtl/de_stage_reg_if.sv
// Decode->Execute bundle: D-side capture fields, stage control and registered E-side outputs.
// Master drives D/control and observes E; slave is the pipeline register itself.
interface de_stage_reg_if #(
    parameter int XLEN  = 32,
    parameter int EXC_W = 5,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             hold_e;
    logic             stall_d;
    logic             valid_d;
    logic [31:0]      ir_d;
    logic [XLEN-1:0]  rs_d;
    logic [XLEN-1:0]  rt_d;
    logic [XLEN-1:0]  pc_d;
    logic             bd_d;
    logic [EXC_W-1:0] exc_d;

    logic             valid_e;
    logic [31:0]      ir_e;
    logic [XLEN-1:0]  rs_e;
    logic [XLEN-1:0]  rt_e;
    logic [XLEN-1:0]  imm_z_e;
    logic [XLEN-1:0]  imm_s_e;
    logic [XLEN-1:0]  imm_u_e;
    logic [XLEN-1:0]  shamt_e;
    logic [XLEN-1:0]  pc_e;
    logic [XLEN-1:0]  pc8_e;
    logic             bd_e;
    logic [EXC_W-1:0] exc_e;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output flush, hold_e, stall_d, valid_d, ir_d, rs_d, rt_d, pc_d, bd_d, exc_d,
        input  valid_e, ir_e, rs_e, rt_e, imm_z_e, imm_s_e, imm_u_e, shamt_e,
               pc_e, pc8_e, bd_e, exc_e, bubble_cnt
    );

    modport slave (
        input  flush, hold_e, stall_d, valid_d, ir_d, rs_d, rt_d, pc_d, bd_d, exc_d,
        output valid_e, ir_e, rs_e, rt_e, imm_z_e, imm_s_e, imm_u_e, shamt_e,
               pc_e, pc8_e, bd_e, exc_e, bubble_cnt
    );
endinterface

// File: rtl/de_stage_reg.sv
// Decode->Execute pipeline register with precomputed immediates/PC+8 and a saturating bubble counter.
// Latency: 1 cycle, all outputs registered.
// Backpressure: hold_e freezes E; stall_d inserts a bubble that keeps PC/BD; flush empties E.
module de_stage_reg #(
    parameter int XLEN  = 32,
    parameter int EXC_W = 5,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    de_stage_reg_if.slave bus
);
    logic             r_valid;
    logic [31:0]      r_ir;
    logic [XLEN-1:0]  r_rs;
    logic [XLEN-1:0]  r_rt;
    logic [XLEN-1:0]  r_imm_z;
    logic [XLEN-1:0]  r_imm_s;
    logic [XLEN-1:0]  r_imm_u;
    logic [XLEN-1:0]  r_shamt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_pc8;
    logic             r_bd;
    logic [EXC_W-1:0] r_exc;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [XLEN-1:0]  w_imm_z;
    logic [XLEN-1:0]  w_imm_s;
    logic [XLEN-1:0]  w_imm_u;
    logic [XLEN-1:0]  w_shamt;
    logic [XLEN-1:0]  w_pc8;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_imm_z = {{(XLEN-16){1'b0}}, bus.ir_d[15:0]};
    assign w_imm_s = {{(XLEN-16){bus.ir_d[15]}}, bus.ir_d[15:0]};
    // Shifting the sign-extended immediate gives lui semantics and sign-extends above bit 31 for XLEN > 32.
    assign w_imm_u = w_imm_s << 16;
    assign w_shamt = {{(XLEN-5){1'b0}}, bus.ir_d[10:6]};
    assign w_pc8   = bus.pc_d + XLEN'(8);

    assign w_cnt_next = (r_bubble_cnt == {CNT_W{1'b1}}) ? r_bubble_cnt : r_bubble_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_ir         <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_imm_z      <= '0;
            r_imm_s      <= '0;
            r_imm_u      <= '0;
            r_shamt      <= '0;
            r_pc         <= '0;
            r_pc8        <= '0;
            r_bd         <= 1'b0;
            r_exc        <= '0;
            r_bubble_cnt <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_ir    <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_imm_z <= '0;
            r_imm_s <= '0;
            r_imm_u <= '0;
            r_shamt <= '0;
            r_pc    <= '0;
            r_pc8   <= '0;
            r_bd    <= 1'b0;
            r_exc   <= '0;
        end else if (bus.hold_e) begin
            r_valid <= r_valid;
        end else if (bus.stall_d) begin
            // Bubble keeps the D slot's PC/BD so an interrupt taken here reports the right EPC.
            r_valid      <= 1'b0;
            r_ir         <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_imm_z      <= '0;
            r_imm_s      <= '0;
            r_imm_u      <= '0;
            r_shamt      <= '0;
            r_pc         <= bus.pc_d;
            r_pc8        <= w_pc8;
            r_bd         <= bus.bd_d;
            r_exc        <= '0;
            r_bubble_cnt <= w_cnt_next;
        end else begin
            r_valid <= bus.valid_d;
            r_ir    <= bus.ir_d;
            r_rs    <= bus.rs_d;
            r_rt    <= bus.rt_d;
            r_imm_z <= w_imm_z;
            r_imm_s <= w_imm_s;
            r_imm_u <= w_imm_u;
            r_shamt <= w_shamt;
            r_pc    <= bus.pc_d;
            r_pc8   <= w_pc8;
            r_bd    <= bus.bd_d;
            r_exc   <= bus.exc_d;
        end
    end

    assign bus.valid_e    = r_valid;
    assign bus.ir_e       = r_ir;
    assign bus.rs_e       = r_rs;
    assign bus.rt_e       = r_rt;
    assign bus.imm_z_e    = r_imm_z;
    assign bus.imm_s_e    = r_imm_s;
    assign bus.imm_u_e    = r_imm_u;
    assign bus.shamt_e    = r_shamt;
    assign bus.pc_e       = r_pc;
    assign bus.pc8_e      = r_pc8;
    assign bus.bd_e       = r_bd;
    assign bus.exc_e      = r_exc;
    assign bus.bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_de_stage_reg.sv
// Bench for de_stage_reg: a 16-bit-counter instance and a 2-bit-counter instance share stimulus.
module tb_de_stage_reg;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    de_stage_reg_if #(.XLEN(32), .EXC_W(5), .CNT_W(16)) bus ();
    de_stage_reg_if #(.XLEN(32), .EXC_W(5), .CNT_W(2))  bus2 ();

    de_stage_reg #(.XLEN(32), .EXC_W(5), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    de_stage_reg #(.XLEN(32), .EXC_W(5), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    assign bus2.flush   = bus.flush;
    assign bus2.hold_e  = bus.hold_e;
    assign bus2.stall_d = bus.stall_d;
    assign bus2.valid_d = bus.valid_d;
    assign bus2.ir_d    = bus.ir_d;
    assign bus2.rs_d    = bus.rs_d;
    assign bus2.rt_d    = bus.rt_d;
    assign bus2.pc_d    = bus.pc_d;
    assign bus2.bd_d    = bus.bd_d;
    assign bus2.exc_d   = bus.exc_d;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir, rs, rt, imm_z, imm_s, imm_u, shamt, pc, pc8;
        logic        bd;
        logic [4:0]  exc;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } eout_t;

    eout_t m;
    eout_t q[$];
    eout_t e, got;
    int checks = 0;
    int errors = 0;

    function automatic eout_t sample();
        eout_t s;
        s.valid = bus.valid_e;   s.ir = bus.ir_e;       s.rs = bus.rs_e;     s.rt = bus.rt_e;
        s.imm_z = bus.imm_z_e;   s.imm_s = bus.imm_s_e; s.imm_u = bus.imm_u_e;
        s.shamt = bus.shamt_e;   s.pc = bus.pc_e;       s.pc8 = bus.pc8_e;
        s.bd = bus.bd_e;         s.exc = bus.exc_e;     s.cnt = bus.bubble_cnt;
        s.cnt2 = bus2.bubble_cnt;
        return s;
    endfunction

    // Drives one cycle of stimulus, pushes the reference E state, and returns #1 after the edge.
    task automatic drive(input logic rst, fl, ho, st, vd, input logic [31:0] ir, rs, rt, pc,
                         input logic bd, input logic [4:0] exc);
        logic [15:0] c;
        logic [1:0]  c2;
        @(negedge clk);
        reset = rst; bus.flush = fl; bus.hold_e = ho; bus.stall_d = st; bus.valid_d = vd;
        bus.ir_d = ir; bus.rs_d = rs; bus.rt_d = rt; bus.pc_d = pc; bus.bd_d = bd; bus.exc_d = exc;
        c = m.cnt; c2 = m.cnt2;
        if (rst) begin
            m = '0;
        end else if (fl) begin
            m = '0; m.cnt = c; m.cnt2 = c2;
        end else if (!ho) begin
            if (st) begin
                m = '0;
                m.pc = pc; m.bd = bd; m.pc8 = pc + 32'd8;
                m.cnt  = (c == 16'hFFFF) ? c : c + 16'd1;
                m.cnt2 = (c2 == 2'd3) ? c2 : c2 + 2'd1;
            end else begin
                m.valid = vd; m.ir = ir; m.rs = rs; m.rt = rt;
                m.imm_z = {16'h0, ir[15:0]};
                m.imm_s = 32'($signed(ir[15:0]));
                m.imm_u = {ir[15:0], 16'h0};
                m.shamt = {27'h0, ir[10:6]};
                m.pc = pc; m.pc8 = pc + 32'd8; m.bd = bd; m.exc = exc;
            end
        end
        q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), 1,
                  $urandom, $urandom, $urandom, $urandom, 1, 5'($urandom));
            e = q.pop_front(); got = sample(); checks++;
            if (got !== e) begin errors++; $display("FAIL reset got=%h exp=%h", got, e); end
        end
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_zero got=%h exp=0", got); end
    endtask

    task automatic test_load();
        drive(0, 0, 0, 0, 1, 32'h2408_FFF0, 32'h1111_2222, 32'h3333_4444, 32'h0000_3000, 0, 0);
        e = q.pop_front(); got = sample(); checks++;
        if (got !== e) begin errors++; $display("FAIL load got=%h exp=%h", got, e); end
        checks++;
        if ({got.ir, got.imm_s, got.imm_z, got.imm_u, got.shamt, got.pc8, got.valid} !==
            {32'h2408FFF0, 32'hFFFFFFF0, 32'h0000FFF0, 32'hFFF00000, 32'h1F, 32'h3008, 1'b1}) begin
            errors++;
            $display("FAIL load_fields got ir=%h s=%h z=%h u=%h sh=%h pc8=%h v=%b exp 2408fff0 fffffff0 0000fff0 fff00000 1f 3008 1",
                     got.ir, got.imm_s, got.imm_z, got.imm_u, got.shamt, got.pc8, got.valid);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 32'h5, 32'h6, 32'h0000_3004, 1, 5'd7);
            e = q.pop_front(); got = sample(); checks++;
            if (got !== e) begin errors++; $display("FAIL stall got=%h exp=%h", got, e); end
        end
        checks++;
        if ({got.ir, got.valid, got.pc, got.bd, got.cnt} !== {32'h0, 1'b0, 32'h3004, 1'b1, 16'd3}) begin
            errors++;
            $display("FAIL stall_fields got ir=%h v=%b pc=%h bd=%b cnt=%0d exp 0 0 3004 1 3",
                     got.ir, got.valid, got.pc, got.bd, got.cnt);
        end
    endtask

    task automatic test_hold_flush();
        drive(0, 0, 0, 0, 1, 32'h2408_FFF0, 32'hA, 32'hB, 32'h0000_3000, 0, 0);
        e = q.pop_front(); got = sample(); checks++;
        if (got !== e) begin errors++; $display("FAIL hold_pre got=%h exp=%h", got, e); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 1, 1, 32'h0BAD_0BAD, 32'hC, 32'hD, 32'h0000_4000, 1, 5'd3);
            e = q.pop_front(); got = sample(); checks++;
            if (got !== e) begin errors++; $display("FAIL hold got=%h exp=%h", got, e); end
        end
        checks++;
        if ({got.ir, got.cnt, got.pc} !== {32'h2408FFF0, 16'd3, 32'h3000}) begin
            errors++;
            $display("FAIL hold_fields got ir=%h cnt=%0d pc=%h exp 2408fff0 3 3000", got.ir, got.cnt, got.pc);
        end
        drive(0, 1, 1, 1, 1, 32'h1234_5678, 32'hE, 32'hF, 32'h0000_5000, 1, 5'd9);
        e = q.pop_front(); got = sample(); checks++;
        if (got !== e) begin errors++; $display("FAIL flush got=%h exp=%h", got, e); end
        checks++;
        if ({got.valid, got.ir, got.rs, got.rt, got.imm_z, got.imm_s, got.imm_u, got.shamt,
             got.pc, got.pc8, got.bd, got.exc} !== '0 || got.cnt !== 16'd3) begin
            errors++;
            $display("FAIL flush_fields got=%h exp fields 0 cnt 3", got);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp2 [5];
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = q.pop_front(); got = sample(); checks++;
        if (got !== e) begin errors++; $display("FAIL sat_reset got=%h exp=%h", got, e); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 1, $urandom, $urandom, $urandom, 32'h100 + 32'(i * 4), 0, 0);
            e = q.pop_front(); got = sample(); checks++;
            if (got !== e) begin errors++; $display("FAIL sat got=%h exp=%h", got, e); end
            checks++;
            if (got.cnt2 !== exp2[i]) begin
                errors++; $display("FAIL sat_cnt2 step %0d got=%0d exp=%0d", i, got.cnt2, exp2[i]);
            end
        end
    endtask

    task automatic test_wrap_exc();
        drive(0, 0, 0, 0, 1, 32'h0000_0000, 32'h1, 32'h2, 32'hFFFF_FFFC, 1, 5'd10);
        e = q.pop_front(); got = sample(); checks++;
        if (got !== e) begin errors++; $display("FAIL wrap got=%h exp=%h", got, e); end
        checks++;
        if ({got.pc8, got.exc} !== {32'h4, 5'd10}) begin
            errors++; $display("FAIL wrap_fields got pc8=%h exc=%0d exp 4 10", got.pc8, got.exc);
        end
        drive(0, 1, 0, 0, 1, 32'h0000_0000, 32'h1, 32'h2, 32'hFFFF_FFFC, 1, 5'd10);
        e = q.pop_front(); got = sample(); checks++;
        if (got.exc !== 5'd0 || got !== e) begin
            errors++; $display("FAIL exc_flush got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_upstream_bubble();
        drive(0, 0, 0, 0, 0, 32'h8C22_0044, 32'h77, 32'h88, 32'h0000_6000, 0, 0);
        e = q.pop_front(); got = sample(); checks++;
        if (got !== e) begin errors++; $display("FAIL up_bubble got=%h exp=%h", got, e); end
        checks++;
        if ({got.valid, got.ir, got.cnt2} !== {1'b0, 32'h8C220044, 2'd3}) begin
            errors++; $display("FAIL up_bubble_fields got v=%b ir=%h cnt2=%0d exp 0 8c220044 3",
                               got.valid, got.ir, got.cnt2);
        end
    endtask

    task automatic test_reset_mid_hold();
        drive(0, 0, 0, 0, 1, 32'h2408_0001, 32'h9, 32'h9, 32'h0000_7000, 1, 5'd2);
        e = q.pop_front(); got = sample(); checks++;
        if (got !== e) begin errors++; $display("FAIL rmh_load got=%h exp=%h", got, e); end
        drive(1, 0, 1, 1, 1, 32'h2408_0002, 32'h9, 32'h9, 32'h0000_7004, 1, 5'd2);
        e = q.pop_front(); got = sample(); checks++;
        if (got !== '0 || got !== e) begin errors++; $display("FAIL reset_mid_hold got=%h exp=0", got); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                  1'($urandom), 5'($urandom));
            e = q.pop_front(); got = sample(); checks++;
            if (got !== e) begin errors++; $display("FAIL b2b cycle %0d got=%h exp=%h", i, got, e); end
        end
    endtask

    initial begin
        m = '0;
        reset = 1'b1;
        bus.flush = 0; bus.hold_e = 0; bus.stall_d = 0; bus.valid_d = 0;
        bus.ir_d = 0; bus.rs_d = 0; bus.rt_d = 0; bus.pc_d = 0; bus.bd_d = 0; bus.exc_d = 0;
        test_reset();
        test_load();
        test_stall();
        test_hold_flush();
        test_saturate();
        test_wrap_exc();
        test_upstream_bubble();
        test_reset_mid_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
